// File: rtl/synth_pkg.sv
// Shared definitions for the synth's slow-rate control blocks.
package synth_pkg;

  // Default amplitude width and the full-scale code at that width.
  localparam int AMP_W_DEF = 16;
  localparam logic [AMP_W_DEF-1:0] AMP_MAX = '1;

  // Default envelope update rate in Hz.
  localparam int TICK_HZ_DEF = 10_000;

  // Envelope stage encoding; codes 5..7 are illegal and recover to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } stage_e;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every CLKSPEED/TICK_HZ clocks.
module tick_gen
  import synth_pkg::*;
#(
  parameter int CLKSPEED = 50_000_000,
  parameter int TICK_HZ  = TICK_HZ_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int P     = CLKSPEED / TICK_HZ;
  localparam int CNT_W = $clog2(P);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(P - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tick on the last count, then wrap to zero.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, otherwise a latch is inferred.
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so all flops update from pre-edge values.
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/adsr_env.sv
// ADSR envelope controller: gate edges act every clock, ramps advance on ticks.
module adsr_env
  import synth_pkg::*;
#(
  parameter int CLKSPEED = 50_000_000,
  parameter int TICK_HZ  = TICK_HZ_DEF,
  parameter int AMP_W    = AMP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gate,
  input  logic [AMP_W-1:0] attack_step,
  input  logic [AMP_W-1:0] decay_step,
  input  logic [AMP_W-1:0] sustain_lvl,
  input  logic [AMP_W-1:0] release_step,
  output logic [AMP_W-1:0] amp,
  output logic [2:0]       stage,
  output logic             busy
);

  // Full-scale code at this instance's width (AMP_MAX when AMP_W is the default).
  localparam logic [AMP_W-1:0] AMP_FULL = '1;

  logic             tick;
  stage_e           stage_q, stage_d;
  logic [AMP_W-1:0] amp_q, amp_d;
  logic             gate_q, gate_d;
  logic             rise, fall;
  logic [AMP_W:0]   attack_sum;
  logic [AMP_W:0]   decay_floor;

  tick_gen #(
    .CLKSPEED (CLKSPEED),
    .TICK_HZ  (TICK_HZ)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // State, amplitude and gate-history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= ST_IDLE;
      amp_q   <= '0;
      gate_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      amp_q   <= amp_d;
      gate_q  <= gate_d;
    end
  end

  // Next state: illegal recovery, then gate edges, then tick-rate ramps.
  always_comb begin
    stage_d = stage_q;
    amp_d   = amp_q;
    gate_d  = gate;
    rise    = gate & ~gate_q;
    fall    = ~gate & gate_q;
    // One extra bit so the attack sum cannot wrap.
    attack_sum = {1'b0, amp_q} + {1'b0, attack_step};
    // amp - decay_step <= sustain rewritten as amp <= decay_step + sustain to avoid underflow.
    decay_floor = {1'b0, decay_step} + {1'b0, sustain_lvl};

    if (stage_q > ST_RELEASE) begin
      stage_d = ST_IDLE;
      amp_d   = '0;
    end else if (rise) begin
      // Retrigger keeps amp so the new attack starts from the current level.
      stage_d = ST_ATTACK;
    end else if (fall && (stage_q inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN})) begin
      stage_d = ST_RELEASE;
    end else if (tick) begin
      case (stage_q)
        ST_IDLE: amp_d = '0;
        ST_ATTACK: begin
          if (attack_step == '0 || attack_sum >= {1'b0, AMP_FULL}) begin
            amp_d   = AMP_FULL;
            stage_d = ST_DECAY;
          end else begin
            amp_d = attack_sum[AMP_W-1:0];
          end
        end
        ST_DECAY: begin
          if (decay_step == '0 || {1'b0, amp_q} <= decay_floor) begin
            amp_d   = sustain_lvl;
            stage_d = ST_SUSTAIN;
          end else begin
            amp_d = amp_q - decay_step;
          end
        end
        ST_SUSTAIN: amp_d = sustain_lvl;
        ST_RELEASE: begin
          if (release_step == '0 || amp_q <= release_step) begin
            amp_d   = '0;
            stage_d = ST_IDLE;
          end else begin
            amp_d = amp_q - release_step;
          end
        end
        default: begin
          stage_d = ST_IDLE;
          amp_d   = '0;
        end
      endcase
    end
  end

  // Outputs come straight from registers; busy is decoded from the registered stage.
  always_comb begin
    amp   = amp_q;
    stage = stage_q;
    busy  = (stage_q != ST_IDLE);
  end

endmodule
